// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - elastic valid/ready pipeline-stage queue with flush, freeze and sticky halt
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             freeze,
  output logic [CNT_W-1:0] count,
  output logic             halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // each entry holds the payload with the halt marker in the top bit
  logic [WIDTH:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               halted_q;
  logic               enq;
  logic               deq;
  logic [WIDTH:0]     head;

  // ready depends only on registered state, never on out_ready
  assign in_ready  = (count_q != FULL_CNT) & ~halted_q;
  assign out_valid = (count_q != '0);

  // flush wins over everything; freeze blocks both sides of the handshake
  assign enq = in_valid & in_ready & ~freeze & ~flush;
  assign deq = out_valid & out_ready & ~freeze & ~flush;

  // head is gated so stale storage never shows after a flush
  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[WIDTH-1:0] : '0;
  assign out_halt = out_valid & head[WIDTH];

  assign count  = count_q;
  assign halted = halted_q;

  // storage write: only an accepted entry touches memory
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wr_ptr] <= {in_halt, in_data};
    end
  end

  // pointers, occupancy and sticky halt; flush squashes and clears halt
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (enq && in_halt) begin
        halted_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised, elastic pipeline-stage register for the MIPS pipeline. It replaces fixed per-stage latches such as ID/EX with a generic WIDTH-bit payload queue of DEPTH entries. It uses a valid/ready handshake, and supports flush (squash), freeze (hold), and sticky halt tracking. It sits between any two pipeline stages; the upstream stage packs its control and data fields into in_data, and the downstream stage unpacks out_data.

Parameters:
WIDTH, 32, payload bits per entry (>=1)
DEPTH, 2, number of entries; power of two, >=2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an entry
in_data  input  WIDTH  upstream payload
in_halt  input  1  entry carries the halt marker
in_ready  output  1  stage can accept an entry this cycle
out_valid  output  1  head entry is valid
out_data  output  WIDTH  head payload
out_halt  output  1  head entry carries the halt marker
out_ready  input  1  downstream consumes the head this cycle
flush  input  1  squash all entries (branch/jump mispredict)
freeze  input  1  hold all state (cache miss stall)
count  output  CNT_W  current occupancy, 0..DEPTH
halted  output  1  sticky: a halt entry has been accepted

Behaviour:
- One clock domain. RST is asynchronous and active-high.
- Reset values: all storage cleared to 0, read/write pointers 0, count=0, out_valid=0, out_data=0, out_halt=0, halted=0, in_ready=1. Asserting RST mid-operation discards all contents immediately, with no completion of in-flight transfers.
- Storage:
  - Circular buffer of DEPTH entries, each WIDTH+1 bits (payload plus halt).
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Handshake signals:
  - enq = in_valid & in_ready & ~freeze & ~flush.
  - deq = out_valid & out_ready & ~freeze & ~flush.
- in_ready = (count != DEPTH) & ~halted. It is a registered-state function only, with no combinational path from out_ready.
- Output path:
  - out_valid = (count != 0).
  - out_data and out_halt are driven from the entry at the read pointer.
  - When out_valid=0, out_data and out_halt read 0.
- Latency: an entry enqueued at edge N is visible on out_* after edge N (1-cycle latency). There is no same-cycle bypass.
- Occupancy updates:
  - enq only: count+1.
  - deq only: count-1.
  - Both: count unchanged, both pointers advance.
  - Full with deq: in_ready=0 that cycle, so only deq occurs and the freed slot is visible next cycle.
- Empty: deq is impossible because out_valid=0. Enq into an empty buffer sets count=1 next cycle.
- freeze=1:
  - No pointer, count, storage, or halted change. Outputs hold their values.
  - in_ready still reflects state but is ignored.
- flush=1 (priority over freeze and handshakes):
  - At the next edge, pointers and count are set to 0, out_valid drops, and halted clears.
  - Storage contents need not be cleared, but out_data must read 0 while empty.
  - An entry offered in the same cycle is discarded.
- Halt tracking:
  - An enq with in_halt=1 sets halted=1 at that edge.
  - While halted=1, in_ready=0 (no younger entries accepted). Entries already in the buffer continue to drain normally.
  - halted clears only on flush or RST.
- count never exceeds DEPTH or underflows. The bench checks this with an assertion.
- No X propagation: all outputs are defined every cycle after reset.

Test Plan:
- Reset/idle: assert RST mid-stream with count=2 -> count=0, out_valid=0, out_data=0, in_ready=1 asynchronously, before the next edge.
- Fill/drain, DEPTH=2, WIDTH=32:
  - Stimulus: push 0xAAAA0001 and 0xAAAA0002 with out_ready=0.
  - Required: count=2, in_ready=0, and a third push is ignored.
  - Then with out_ready=1: out_data=0xAAAA0001, then 0xAAAA0002, in order, then out_valid=0.
- Simultaneous enq/deq:
  - Stimulus: count=1, continuous push 0x10, 0x11, 0x12 with out_ready=1.
  - Required: count stays 1 and outputs follow 1 cycle behind, with pointer wrap across DEPTH exercised.
- Freeze and flush:
  - Stimulus: freeze=1 for 3 cycles with in_valid=1 and out_ready=1.
  - Required: count and out_data unchanged.
  - Stimulus: flush=1 together with freeze=1 and in_valid=1.
  - Required: next cycle count=0, out_valid=0, and the offered entry is dropped.
- Halt:
  - Stimulus: push 0x1 (in_halt=1) then 0x2.
  - Required: halted=1 and in_ready=0 after the first edge, so 0x2 is never accepted. 0x1 drains with out_halt=1.
  - Stimulus: flush.
  - Required: halted=0 and in_ready=1.
- Parameter sweep: repeat the fill/drain scenario with DEPTH=4 and WIDTH=8 -> count reaches 4, order is preserved, and count never exceeds 4 under random valid/ready/freeze.
